// File: rtl/display_pkg.sv
// Shared definitions for the display arbiter: FSM encoding, default timing
// parameters and a helper that sizes counters from their terminal count.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int DEFAULT_REFRESH_DIV = 100000;
  localparam int DEFAULT_HOLD_TICKS  = 2000;
  localparam int DEFAULT_BLINK_TICKS = 250;

  // Width of a counter that runs 0..n-1; never narrower than one bit so a
  // terminal count of 1 still yields a legal vector.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every DIV clocks, the first
// one DIV clocks after reset is released.
module tick_gen
  import display_pkg::*;
#(
  parameter int DIV = DEFAULT_REFRESH_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = ctr_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Count 0..DIV-1 and register the tick on the wrap so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= (count == LAST);
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Chooses what the seven-segment mux shows: the live source 0 value, or a
// message from source 1/2 held for a fixed number of refresh ticks and then
// acknowledged. Also generates the refresh tick and blank/blink control.
module display_arbiter
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int HOLD_TICKS  = DEFAULT_HOLD_TICKS,
  parameter int BLINK_TICKS = DEFAULT_BLINK_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src0_bcd,
  input  logic [7:0]  src0_dots,
  input  logic        src0_neg,
  input  logic [1:0]  req,
  input  logic [31:0] msg1_bcd,
  input  logic [7:0]  msg1_dots,
  input  logic        msg1_neg,
  input  logic [31:0] msg2_bcd,
  input  logic [7:0]  msg2_dots,
  input  logic        msg2_neg,
  output logic [1:0]  ack,
  input  logic        blank,
  input  logic        blink,
  output logic        clk_enable,
  output logic [31:0] bcd,
  output logic [7:0]  dots,
  output logic        is_negative,
  output logic        turn_off
);

  localparam int HW = ctr_width(HOLD_TICKS);
  localparam int BW = ctr_width(BLINK_TICKS);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  state_t        state;
  logic          last_src2;
  logic          cur_src2;
  logic          pick_src2;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          blink_toggle;
  logic          phase_next;

  tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (clk_enable)
  );

  // Source 2 wins when it is the only requester, or on a tie when source 1
  // was the last one served.
  assign pick_src2    = req[1] & (~req[0] | ~last_src2);
  assign blink_toggle = clk_enable & (blink_cnt == BLINK_LAST);
  assign phase_next   = blink & (blink_phase ^ blink_toggle);

  // Arbitration FSM with registered payload and ack outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_src2   <= 1'b1;
      cur_src2    <= 1'b0;
      hold_cnt    <= '0;
      ack         <= 2'b00;
      bcd         <= 32'h0;
      dots        <= 8'h0;
      is_negative <= 1'b0;
    end else begin
      ack <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state     <= ST_SHOW;
            last_src2 <= pick_src2;
            cur_src2  <= pick_src2;
            hold_cnt  <= '0;
            if (pick_src2) begin
              bcd         <= msg2_bcd;
              dots        <= msg2_dots;
              is_negative <= msg2_neg;
            end else begin
              bcd         <= msg1_bcd;
              dots        <= msg1_dots;
              is_negative <= msg1_neg;
            end
          end else begin
            bcd         <= src0_bcd;
            dots        <= src0_dots;
            is_negative <= src0_neg;
          end
        end
        ST_SHOW: begin
          if (clk_enable) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_ACK;
              hold_cnt <= '0;
              ack      <= cur_src2 ? 2'b10 : 2'b01;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        ST_ACK: begin
          state       <= ST_IDLE;
          bcd         <= src0_bcd;
          dots        <= src0_dots;
          is_negative <= src0_neg;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Blank overrides everything; otherwise blink flips the display every
  // BLINK_TICKS refresh ticks, and dropping blink restarts the phase at on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      turn_off    <= 1'b1;
    end else begin
      blink_phase <= phase_next;
      turn_off    <= blank | phase_next;
      if (!blink) begin
        blink_cnt <= '0;
      end else if (clk_enable) begin
        if (blink_cnt == BLINK_LAST) blink_cnt <= '0;
        else                         blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter. A transaction-level reference
// model (tick total, grant deadline, owner/ack bookkeeping) predicts every
// output each cycle; vectors are {bcd, dots, is_negative, ack, turn_off,
// clk_enable}.
module tb_display_arbiter;

  localparam int DIV  = 4;
  localparam int HOLD = 3;
  localparam int BT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src0_bcd = 32'h0;
  logic [7:0]  src0_dots = 8'h0;
  logic        src0_neg = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] msg1_bcd = 32'h0;
  logic [7:0]  msg1_dots = 8'h0;
  logic        msg1_neg = 1'b0;
  logic [31:0] msg2_bcd = 32'h0;
  logic [7:0]  msg2_dots = 8'h0;
  logic        msg2_neg = 1'b0;
  logic        blank = 1'b0;
  logic        blink = 1'b0;
  logic [1:0]  ack;
  logic        clk_enable;
  logic [31:0] bcd;
  logic [7:0]  dots;
  logic        is_negative;
  logic        turn_off;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_cyc;
  int          m_tot;
  int          m_owner;
  int          m_last;
  int          m_deadline;
  int          m_blink_n;
  logic        m_ce;
  logic [31:0] m_bcd;
  logic [7:0]  m_dots;
  logic        m_neg;
  logic [1:0]  m_ack;
  logic        m_turn_off;

  wire [44:0] dut_vec = {bcd, dots, is_negative, ack, turn_off, clk_enable};
  wire [44:0] exp_vec = {m_bcd, m_dots, m_neg, m_ack, m_turn_off, m_ce};

  display_arbiter #(
    .REFRESH_DIV (DIV),
    .HOLD_TICKS  (HOLD),
    .BLINK_TICKS (BT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src0_bcd    (src0_bcd),
    .src0_dots   (src0_dots),
    .src0_neg    (src0_neg),
    .req         (req),
    .msg1_bcd    (msg1_bcd),
    .msg1_dots   (msg1_dots),
    .msg1_neg    (msg1_neg),
    .msg2_bcd    (msg2_bcd),
    .msg2_dots   (msg2_dots),
    .msg2_neg    (msg2_neg),
    .ack         (ack),
    .blank       (blank),
    .blink       (blink),
    .clk_enable  (clk_enable),
    .bcd         (bcd),
    .dots        (dots),
    .is_negative (is_negative),
    .turn_off    (turn_off)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Hard stop in case a wait somewhere never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_cyc = 0; m_tot = 0; m_owner = 0; m_last = 2; m_deadline = 0;
    m_blink_n = 0; m_ce = 1'b0; m_bcd = 32'h0; m_dots = 8'h0; m_neg = 1'b0;
    m_ack = 2'b00; m_turn_off = 1'b1;
  endtask

  task automatic model_step();
    logic       ce_old;
    int         tot_new;
    logic [1:0] ack_old;
    int         pick;
    if (rst) begin
      model_reset();
      return;
    end
    ce_old  = m_ce;
    tot_new = m_tot + (ce_old ? 1 : 0);
    m_cyc   = m_cyc + 1;
    m_ce    = ((m_cyc % DIV) == 0);
    if (blink) m_blink_n = m_blink_n + (ce_old ? 1 : 0);
    else       m_blink_n = 0;
    m_turn_off = blank || (blink && (((m_blink_n / BT) % 2) == 1));
    ack_old = m_ack;
    m_ack   = 2'b00;
    if (ack_old != 2'b00) begin
      m_bcd = src0_bcd; m_dots = src0_dots; m_neg = src0_neg;
    end else if (m_owner != 0) begin
      if (tot_new == m_deadline) begin
        m_ack   = (m_owner == 1) ? 2'b01 : 2'b10;
        m_owner = 0;
      end
    end else if (req != 2'b00) begin
      if (req == 2'b11) pick = (m_last == 1) ? 2 : 1;
      else              pick = (req == 2'b01) ? 1 : 2;
      m_owner    = pick;
      m_last     = pick;
      m_deadline = tot_new + HOLD;
      if (pick == 1) begin
        m_bcd = msg1_bcd; m_dots = msg1_dots; m_neg = msg1_neg;
      end else begin
        m_bcd = msg2_bcd; m_dots = msg2_dots; m_neg = msg2_neg;
      end
    end else begin
      m_bcd = src0_bcd; m_dots = src0_dots; m_neg = src0_neg;
    end
    m_tot = tot_new;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    src0_bcd = 32'h12345678; src0_dots = 8'h5A; src0_neg = 1'b1;
    cycle();
    cycle();
    checks++;
    if (dut_vec !== {32'h0, 8'h0, 1'b0, 2'b00, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_values got=%h required=%h", dut_vec,
               {32'h0, 8'h0, 1'b0, 2'b00, 1'b1, 1'b0});
    end
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL reset_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
      end
      if (i == 1) begin
        checks++;
        if (bcd !== 32'h12345678 || turn_off !== 1'b0) begin
          failures++;
          $display("[TB] FAIL reset_release got bcd=%h off=%b required bcd=12345678 off=0",
                   bcd, turn_off);
        end
      end
      checks++;
      if (clk_enable !== ((i % DIV) == 0)) begin
        failures++;
        $display("[TB] FAIL tick_cadence cycle=%0d got=%b required=%b", i, clk_enable,
                 ((i % DIV) == 0));
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] s0;
    bit          got;
    s0 = $urandom;
    src0_bcd = s0;
    msg1_bcd = 32'hE0000001; msg1_dots = 8'($urandom); msg1_neg = 1'($urandom);
    req = 2'b01;
    cycle();
    checks++;
    if (dut_vec !== exp_vec || bcd !== 32'hE0000001) begin
      failures++;
      $display("[TB] FAIL single_grant got=%h exp=%h", dut_vec, exp_vec);
    end
    got = 1'b0;
    for (int t = 1; t <= 40 && !got; t++) begin
      msg1_bcd = $urandom; msg1_dots = 8'($urandom); msg2_bcd = $urandom;
      req = {1'b0, 1'($urandom)};
      cycle();
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL single_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
      end
      if (ack !== 2'b00) begin
        got = 1'b1;
        checks++;
        if (ack !== 2'b01 || t < (HOLD - 1) * DIV + 1 || t > HOLD * DIV) begin
          failures++;
          $display("[TB] FAIL single_ack got ack=%b after %0d cycles required ack=01 within %0d..%0d",
                   ack, t, (HOLD - 1) * DIV + 1, HOLD * DIV);
        end
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL single_timeout got no ack required ack=01");
    end
    req = 2'b00;
    cycle();
    checks++;
    if (bcd !== s0 || ack !== 2'b00 || dut_vec !== exp_vec) begin
      failures++;
      $display("[TB] FAIL single_return got bcd=%h ack=%b required bcd=%h ack=00", bcd, ack, s0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  acks [2];
    int          nacks;
    bit          after_first;
    logic [31:0] s0;
    do_reset();
    s0 = 32'h00C0FFEE;
    src0_bcd = s0;
    msg1_bcd = 32'hA1111111; msg2_bcd = 32'hB2222222;
    acks[0] = 2'b00; acks[1] = 2'b00;
    nacks = 0;
    after_first = 1'b0;
    req = 2'b11;
    for (int t = 0; t < 80 && nacks < 2; t++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL rr_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
      end
      if (after_first) begin
        after_first = 1'b0;
        checks++;
        if (bcd !== s0) begin
          failures++;
          $display("[TB] FAIL rr_idle_gap got bcd=%h required bcd=%h", bcd, s0);
        end
      end
      if (ack !== 2'b00) begin
        acks[nacks] = ack;
        nacks++;
        if (nacks == 1) after_first = 1'b1;
      end
    end
    req = 2'b00;
    checks++;
    if (nacks != 2 || acks[0] !== 2'b01 || acks[1] !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rr_order got n=%0d acks=%b,%b required n=2 acks=01,10",
               nacks, acks[0], acks[1]);
    end
    cycle();
  endtask

  task automatic test_random();
    int nack;
    nack = 0;
    for (int t = 0; t < 300; t++) begin
      src0_bcd = $urandom; src0_dots = 8'($urandom); src0_neg = 1'($urandom);
      msg1_bcd = $urandom; msg1_dots = 8'($urandom); msg1_neg = 1'($urandom);
      msg2_bcd = $urandom; msg2_dots = 8'($urandom); msg2_neg = 1'($urandom);
      for (int k = 0; k < 2; k++) begin
        if (m_ack[k])      req[k] = 1'b0;
        else if (!req[k])  req[k] = ($urandom_range(0, 7) == 0);
        else if ($urandom_range(0, 31) == 0) req[k] = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) blank = ~blank;
      if ($urandom_range(0, 39) == 0) blink = ~blink;
      cycle();
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL random_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
      end
      if (m_ack != 2'b00) nack++;
    end
    req = 2'b00; blank = 1'b0; blink = 1'b0;
    cycle();
    cycle();
    checks++;
    if (nack == 0 || dut_vec !== exp_vec) begin
      failures++;
      $display("[TB] FAIL random_end got=%h exp=%h acks=%0d", dut_vec, exp_vec, nack);
    end
  endtask

  task automatic test_reset_mid_show();
    logic [31:0] s0;
    s0 = 32'h87654321;
    src0_bcd = s0;
    msg2_bcd = 32'hDEADBEEF;
    req = 2'b10;
    cycle();
    for (int t = 0; t < 4; t++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec || bcd !== 32'hDEADBEEF) begin
        failures++;
        $display("[TB] FAIL midshow_model got=%h exp=%h", dut_vec, exp_vec);
      end
    end
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (bcd !== 32'h0 || turn_off !== 1'b1 || ack !== 2'b00 || clk_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midshow_async got bcd=%h off=%b ack=%b ce=%b required 0,1,00,0",
               bcd, turn_off, ack, clk_enable);
    end
    req = 2'b00;
    cycle();
    cycle();
    rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec || ack !== 2'b00) begin
        failures++;
        $display("[TB] FAIL midshow_after t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
      end
    end
    checks++;
    if (bcd !== s0) begin
      failures++;
      $display("[TB] FAIL midshow_src0 got bcd=%h required %h", bcd, s0);
    end
  endtask

  task automatic test_blink();
    int k;
    for (int t = 0; t < 4 && m_ce; t++) cycle();
    blink = 1'b1;
    k = 0;
    for (int n = 0; n < 100 && k < 12; n++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL blink_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
      end
      if (m_ce) begin
        k++;
        checks++;
        if (turn_off !== ((((k - 1) / BT) % 2) == 1)) begin
          failures++;
          $display("[TB] FAIL blink_pattern tick=%0d got=%b required=%b", k, turn_off,
                   ((((k - 1) / BT) % 2) == 1));
        end
      end
    end
    if (k < 12) begin
      checks++;
      failures++;
      $display("[TB] FAIL blink_timeout got %0d ticks required 12", k);
    end
    blink = 1'b0;
    cycle();
    checks++;
    if (turn_off !== 1'b0) begin
      failures++;
      $display("[TB] FAIL blink_release got off=%b required 0", turn_off);
    end
  endtask

  task automatic test_blank();
    bit got;
    req = 2'b01;
    msg1_bcd = 32'h0BADF00D;
    cycle();
    blank = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec || turn_off !== 1'b1) begin
        failures++;
        $display("[TB] FAIL blank_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
      end
      if (ack !== 2'b00) begin
        got = 1'b1;
        checks++;
        if (ack !== 2'b01) begin
          failures++;
          $display("[TB] FAIL blank_ack got ack=%b required 01", ack);
        end
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL blank_timeout got no ack required ack=01");
    end
    blank = 1'b0;
    req = 2'b00;
    cycle();
    checks++;
    if (turn_off !== 1'b0 || dut_vec !== exp_vec) begin
      failures++;
      $display("[TB] FAIL blank_release got off=%b required 0", turn_off);
    end
  endtask

  // Scenario sequence
  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_reset_mid_show();
    test_blink();
    test_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
